mod_mul_seq: RTL and testbench
==============================

MOD_MUL_SEQ -- requirements
Module: mod_mul_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  single-cycle start pulse from the upstream level-to-pulse stage.
REQ-005 The block SHALL have port a  input  WIDTH  multiplicand, unsigned, required a < n.
REQ-006 The block SHALL have port b  input  WIDTH  multiplier, unsigned, any value.
REQ-007 The block SHALL have port n  input  WIDTH  modulus, unsigned, required n != 0.
REQ-008 The block SHALL have port result  output  WIDTH  (a*b) mod n, registered.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking result/err valid.
REQ-010 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 The block SHALL have port err  output  1  operand error flag, registered, valid with done.

Function
REQ-012 The block SHALL implement a Moore FSM with states IDLE, CALC, DONE.
REQ-013 In IDLE, if start=1 at a rising edge, the block SHALL latch a, b, n into internal registers and clear the accumulator R to 0.
REQ-014 In that same edge, if n=0 or a>=n, the block SHALL go to DONE with result=0 and err=1; otherwise it SHALL go to CALC with bit index i=WIDTH-1 and err=0.
REQ-015 In CALC, each edge SHALL process one multiplier bit, MSB first: R=2R; if R>=N then R=R-N; if b[i]=1 then R=R+A; if R>=N then R=R-N.
REQ-016 The intermediate arithmetic SHALL be WIDTH+1 bits wide so that 2R and R+A (each < 2N) never overflow.
REQ-017 After processing i=0, the block SHALL load result with the final R and go to DONE; otherwise it SHALL decrement i and stay in CALC.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 Latency SHALL be fixed: for a valid operation sampled at edge k, done=1 in the cycle after edge k+WIDTH (k+32 at default); for an error operation, done=1 in the cycle after edge k.
REQ-020 busy SHALL be 1 whenever state != IDLE and SHALL be 0 in IDLE.
REQ-021 start SHALL be ignored in CALC and DONE; no queuing; internal operands SHALL NOT change while busy.
REQ-022 Changes on a, b, n after the start edge SHALL NOT affect the running operation.
REQ-023 result and err SHALL hold their last values in IDLE until the next accepted start updates them.
REQ-024 The block SHALL return R < N after every CALC step; for n=1 the result SHALL be 0 with err=0.
REQ-025 start held high for more than one cycle SHALL be accepted only at the IDLE edge; any remaining high cycles fall within CALC and are ignored.

Reset
REQ-026 On rstn=0, the block SHALL immediately go to IDLE and set result=0, done=0, busy=0, err=0, R=0 and i=0, independent of clk.
REQ-027 A reset asserted mid-CALC SHALL abort the operation with no done pulse; the first start after rstn returns to 1 SHALL begin a fresh operation.

Verification
REQ-028 The bench SHALL check: a=3, b=5, n=7, one start pulse -> done after 32 cycles, result=1, err=0, busy high for 33 cycles.
REQ-029 The bench SHALL check: a=0xFFFFFFFE, b=0xFFFFFFFE, n=0xFFFFFFFF -> result=0x00000001, with no overflow of the intermediate values.
REQ-030 The bench SHALL check: n=0 (any a, b), then a=5, b=3, n=5 -> each gives done one cycle after start, result=0, err=1.
REQ-031 The bench SHALL check: a=2, b=0, n=11 -> result=0; then a=10, b=1, n=11 -> result=10, with result held stable in IDLE between the two operations.
REQ-032 The bench SHALL check: a second start 10 cycles into an operation, with a, b, n changed -> ignored; the first operation's result is unchanged and only one done pulse occurs.
REQ-033 The bench SHALL check: rstn pulsed low at cycle 15 of CALC -> all outputs 0 at once, no done pulse; then a=3, b=5, n=7 completes with result=1.

Source files
------------

// File: rtl/mod_mul_seq_if.sv
// Operand/result bundle for the sequential modular multiplier.
// The master drives operands and start; the slave returns result and status.
interface mod_mul_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             err;

  modport master (
    output start, a, b, n,
    input  result, done, busy, err
  );

  modport slave (
    input  start, a, b, n,
    output result, done, busy, err
  );
endinterface

// File: rtl/mod_mul_seq.sv
// Bit-serial (a*b) mod n using MSB-first interleaved shift/add with reduction.
// One multiplier bit per cycle; fixed latency of WIDTH cycles for valid operands.
module mod_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rstn,
  mod_mul_seq_if.slave  bus
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [IW-1:0]    i_q, i_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // One reduction step; widths carry one guard bit so 2R and R+A (< 2N) fit.
  logic [WIDTH:0]   n_ext;
  logic [WIDTH:0]   dbl;
  logic [WIDTH:0]   dbl_red;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] r_step;

  always_comb begin
    n_ext   = {1'b0, n_q};
    dbl     = {r_q, 1'b0};
    dbl_red = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
    acc     = b_q[i_q] ? (dbl_red + {1'b0, a_q}) : dbl_red;
    r_step  = WIDTH'((acc >= n_ext) ? (acc - n_ext) : acc);
  end

  // Next-state and register next-values
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    r_d      = r_q;
    i_d      = i_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d = bus.a;
          b_d = bus.b;
          n_d = bus.n;
          r_d = '0;
          if ((bus.n == '0) || (bus.a >= bus.n)) begin
            state_d  = DONE;
            result_d = '0;
            err_d    = 1'b1;
          end else begin
            state_d = CALC;
            i_d     = IW'(WIDTH - 1);
            err_d   = 1'b0;
          end
        end
      end
      CALC: begin
        r_d = r_step;
        if (i_q == '0) begin
          result_d = r_step;
          state_d  = DONE;
        end else begin
          i_d = i_q - IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      r_q      <= r_d;
      i_q      <= i_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mod_mul_seq.sv
// Directed-vector bench for mod_mul_seq with a scoreboard queue and a
// done-triggered monitor; stimulus tasks also check latency and busy length.
module tb_mod_mul_seq;

  localparam int unsigned WIDTH = 32;
  localparam int          LAT_OK  = WIDTH + 1;
  localparam int          LAT_ERR = 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             err;
  } exp_t;

  logic clk;
  logic rstn;

  mod_mul_seq_if #(.WIDTH(WIDTH)) bus ();

  mod_mul_seq #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   done_count = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse consumes one expected response
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("result", 64'(bus.result), 64'(e.res));
        check("err", 64'(bus.err), 64'(e.err));
      end
    end
  end

  task automatic pulse_start(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                             input logic [WIDTH-1:0] tn);
    @(posedge clk); #1;
    bus.a = ta; bus.b = tb_; bus.n = tn; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Issue one operation, then check done latency, busy length and return to idle
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic [WIDTH-1:0] tn, input logic [WIDTH-1:0] er,
                        input logic ee, input string nm);
    int lat;
    int bcnt;
    bit seen;
    exp_q.push_back('{res: er, err: ee});
    pulse_start(ta, tb_, tn);
    lat = 0; bcnt = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.busy === 1'b1) bcnt++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({nm, "_latency"}, 64'(lat), 64'(ee ? LAT_ERR : LAT_OK));
    check({nm, "_busy_cycles"}, 64'(bcnt), 64'(ee ? LAT_ERR : LAT_OK));
    @(negedge clk);
    check({nm, "_busy_after"}, 64'(bus.busy), 64'(0));
    check({nm, "_done_one_cycle"}, 64'(bus.done), 64'(0));
  endtask

  task automatic hold_check(input logic [WIDTH-1:0] er, input logic ee, input string nm);
    @(posedge clk); #1;
    bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0; bus.n = 32'h0000_0003;
    repeat (4) @(negedge clk);
    check({nm, "_result_hold"}, 64'(bus.result), 64'(er));
    check({nm, "_err_hold"}, 64'(bus.err), 64'(ee));
    check({nm, "_busy_idle"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    int dc;
    int guard;
    rstn = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.n = '0;
    repeat (3) @(negedge clk);
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_err", 64'(bus.err), 64'(0));
    @(posedge clk); #1;
    rstn = 1'b1;

    // Basic: 15 mod 7 = 1
    run_op(32'd3, 32'd5, 32'd7, 32'd1, 1'b0, "basic");

    // Near-max operands: (-1)*(-1) mod n = 1
    run_op(32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "maxop");

    // Operand errors
    run_op(32'd9, 32'd4, 32'd0, 32'd0, 1'b1, "n_zero");
    run_op(32'd5, 32'd3, 32'd5, 32'd0, 1'b1, "a_ge_n");

    // Zero multiplier, then single add, with idle holds in between
    run_op(32'd2, 32'd0, 32'd11, 32'd0, 1'b0, "b_zero");
    hold_check(32'd0, 1'b0, "idle0");
    run_op(32'd10, 32'd1, 32'd11, 32'd10, 1'b0, "b_one");
    hold_check(32'd10, 1'b0, "idle10");

    // Modulus of one and a mid-size product
    run_op(32'd0, 32'd123, 32'd1, 32'd0, 1'b0, "n_one");
    run_op(32'd123456, 32'd654321, 32'd1000003, 32'd611039, 1'b0, "mid");

    // Second start mid-operation with changed operands must be ignored
    dc = done_count;
    exp_q.push_back('{res: 32'd1, err: 1'b0});
    pulse_start(32'd3, 32'd5, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    bus.a = 32'd6; bus.b = 32'd6; bus.n = 32'd13; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (60) @(negedge clk);
    check("ignored_start_done_count", 64'(done_count - dc), 64'(1));
    check("ignored_start_idle", 64'(bus.busy), 64'(0));

    // Reset mid-CALC aborts without a done pulse
    dc = done_count;
    pulse_start(32'd3, 32'd5, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    check("pre_abort_busy", 64'(bus.busy), 64'(1));
    rstn = 1'b0;
    #1;
    check("abort_result", 64'(bus.result), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_err", 64'(bus.err), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_count - dc), 64'(0));
    run_op(32'd3, 32'd5, 32'd7, 32'd1, 1'b0, "after_abort");

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
